// File: rtl/crazy_light_monitor.sv
// crazy_light_monitor: receive-side checker for the RGB colour sequencer.
// Decodes r/g/b to a colour index, tracks the red..magenta cycle, and
// reports lock/halt status, sequence errors, completed laps and errors.
module crazy_light_monitor #(
    parameter int unsigned LAP_W      = 8,
    parameter int unsigned ERR_W      = 8,
    parameter bit          ALLOW_HOLD = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       r,
    input  logic [3:0]       g,
    input  logic [3:0]       b,
    input  logic             cnt_clear,
    output logic [2:0]       color_idx,
    output logic             locked,
    output logic             halted,
    output logic             seq_error,
    output logic [LAP_W-1:0] lap_count,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        TRACK   = 2'd1,
        HALTED  = 2'd2
    } state_t;

    localparam logic [2:0] IDX_MAGENTA = 3'd5;
    localparam logic [2:0] IDX_OFF     = 3'd6;
    localparam logic [2:0] IDX_INVALID = 3'd7;

    state_t           state_q, state_d;
    logic [2:0]       prev_q, prev_d;
    logic [2:0]       color_idx_q, color_idx_d;
    logic             locked_q, locked_d;
    logic             halted_q, halted_d;
    logic             seq_error_q, seq_error_d;
    logic [LAP_W-1:0] lap_count_q, lap_count_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    logic [2:0]       c;
    logic [2:0]       next_col;
    logic             err_hit;
    logic             lap_hit;

    // Decode the raw channel nibbles; anything not fully on/off is invalid.
    always_comb begin
        c = IDX_INVALID;
        case ({r, g, b})
            12'hF00: c = 3'd0;
            12'hFF0: c = 3'd1;
            12'h0F0: c = 3'd2;
            12'h0FF: c = 3'd3;
            12'h00F: c = 3'd4;
            12'hF0F: c = 3'd5;
            12'h000: c = IDX_OFF;
            default: c = IDX_INVALID;
        endcase
    end

    // Sequence FSM: next state, accepted colour, error and lap events.
    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        err_hit  = 1'b0;
        lap_hit  = 1'b0;
        next_col = (prev_q == IDX_MAGENTA) ? 3'd0 : prev_q + 3'd1;
        case (state_q)
            ACQUIRE: begin
                if (c <= IDX_MAGENTA) begin
                    state_d = TRACK;
                    prev_d  = c;
                end else if (c == IDX_OFF) begin
                    state_d = HALTED;
                end
            end
            TRACK: begin
                if (c == next_col) begin
                    prev_d  = c;
                    lap_hit = (prev_q == IDX_MAGENTA);
                end else if (c == IDX_OFF) begin
                    state_d = HALTED;
                end else if (ALLOW_HOLD && (c == prev_q)) begin
                    state_d = TRACK;
                end else begin
                    err_hit = 1'b1;
                    state_d = ACQUIRE;
                end
            end
            HALTED: begin
                if (c == 3'd0) begin
                    state_d = TRACK;
                    prev_d  = 3'd0;
                end else if (c != IDX_OFF) begin
                    err_hit = 1'b1;
                    state_d = ACQUIRE;
                end
            end
            default: begin
                state_d = ACQUIRE;
            end
        endcase
    end

    // Registered status and counters; cnt_clear beats a same-cycle increment.
    always_comb begin
        color_idx_d = c;
        locked_d    = (state_d == TRACK);
        halted_d    = (state_d == HALTED);
        seq_error_d = err_hit;
        lap_count_d = lap_count_q;
        err_count_d = err_count_q;
        if (lap_hit) begin
            lap_count_d = lap_count_q + LAP_W'(1);
        end
        if (err_hit && (err_count_q != '1)) begin
            err_count_d = err_count_q + ERR_W'(1);
        end
        if (cnt_clear) begin
            lap_count_d = '0;
            err_count_d = '0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ACQUIRE;
            prev_q      <= '0;
            color_idx_q <= IDX_INVALID;
            locked_q    <= 1'b0;
            halted_q    <= 1'b0;
            seq_error_q <= 1'b0;
            lap_count_q <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            color_idx_q <= color_idx_d;
            locked_q    <= locked_d;
            halted_q    <= halted_d;
            seq_error_q <= seq_error_d;
            lap_count_q <= lap_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign color_idx = color_idx_q;
    assign locked    = locked_q;
    assign halted    = halted_q;
    assign seq_error = seq_error_q;
    assign lap_count = lap_count_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_crazy_light_monitor.sv
// Testbench for crazy_light_monitor: two instances (default parameters and
// LAP_W=3/ERR_W=2/ALLOW_HOLD=1) share directed stimulus and are checked
// every cycle against a behavioural model, plus hand-computed literals.
module tb_crazy_light_monitor;

    localparam int RED = 0, YEL = 1, GRN = 2, CYN = 3, BLU = 4, MAG = 5, OFF = 6;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] r = 4'h0, g = 4'h0, b = 4'h0;
    logic       cnt_clear = 1'b0;

    logic [2:0] ci0, ci1;
    logic       lk0, lk1, hl0, hl1, se0, se1;
    logic [7:0] lap0, err0;
    logic [2:0] lap1;
    logic [1:0] err1;

    crazy_light_monitor u0 (
        .clock(clock), .reset(reset), .r(r), .g(g), .b(b), .cnt_clear(cnt_clear),
        .color_idx(ci0), .locked(lk0), .halted(hl0), .seq_error(se0),
        .lap_count(lap0), .err_count(err0)
    );

    crazy_light_monitor #(.LAP_W(3), .ERR_W(2), .ALLOW_HOLD(1'b1)) u1 (
        .clock(clock), .reset(reset), .r(r), .g(g), .b(b), .cnt_clear(cnt_clear),
        .color_idx(ci1), .locked(lk1), .halted(hl1), .seq_error(se1),
        .lap_count(lap1), .err_count(err1)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Model: mode 0 = acquiring, 1 = tracking, 2 = halted.
    int LAPMOD[2] = '{256, 8};
    int ERRMAX[2] = '{255, 3};
    int HOLD[2]   = '{0, 1};
    int m_mode[2], m_prev[2], m_lap[2], m_err[2], m_serr[2], m_cidx[2];

    logic [11:0] pat [0:6] = '{12'hF00, 12'hFF0, 12'h0F0, 12'h0FF, 12'h00F, 12'hF0F, 12'h000};

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    function automatic int mdecode(input logic [3:0] rr, input logic [3:0] gg, input logic [3:0] bb);
        int key;
        if (!(rr inside {4'h0, 4'hF}) || !(gg inside {4'h0, 4'hF}) || !(bb inside {4'h0, 4'hF}))
            return 7;
        key = (rr != 0 ? 4 : 0) + (gg != 0 ? 2 : 0) + (bb != 0 ? 1 : 0);
        case (key)
            4: return 0;
            6: return 1;
            2: return 2;
            3: return 3;
            1: return 4;
            5: return 5;
            0: return 6;
            default: return 7;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_prev[k] = 0; m_lap[k] = 0;
            m_err[k] = 0; m_serr[k] = 0; m_cidx[k] = 7;
        end
    endtask

    task automatic model_step(input int c, input bit clr);
        for (int k = 0; k < 2; k++) begin
            bit err = 1'b0;
            bit lap = 1'b0;
            if (m_mode[k] == 0) begin
                if (c <= 5) begin m_mode[k] = 1; m_prev[k] = c; end
                else if (c == 6) m_mode[k] = 2;
            end else if (m_mode[k] == 1) begin
                if (c == (m_prev[k] + 1) % 6) begin
                    lap = (m_prev[k] == 5);
                    m_prev[k] = c;
                end else if (c == 6) m_mode[k] = 2;
                else if (!(c == m_prev[k] && HOLD[k] == 1)) err = 1'b1;
            end else begin
                if (c == 0) begin m_mode[k] = 1; m_prev[k] = 0; end
                else if (c != 6) err = 1'b1;
            end
            if (err) m_mode[k] = 0;
            m_serr[k] = err;
            m_cidx[k] = c;
            if (lap) m_lap[k] = (m_lap[k] + 1) % LAPMOD[k];
            if (err && m_err[k] < ERRMAX[k]) m_err[k]++;
            if (clr) begin m_lap[k] = 0; m_err[k] = 0; end
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            check("u0.color_idx", ci0, m_cidx[0]);
            check("u0.locked", lk0, m_mode[0] == 1);
            check("u0.halted", hl0, m_mode[0] == 2);
            check("u0.seq_error", se0, m_serr[0]);
            check("u0.lap_count", lap0, m_lap[0]);
            check("u0.err_count", err0, m_err[0]);
            check("u1.color_idx", ci1, m_cidx[1]);
            check("u1.locked", lk1, m_mode[1] == 1);
            check("u1.halted", hl1, m_mode[1] == 2);
            check("u1.seq_error", se1, m_serr[1]);
            check("u1.lap_count", lap1, m_lap[1]);
            check("u1.err_count", err1, m_err[1]);
        end
    end

    task automatic step(input logic [3:0] rr, input logic [3:0] gg, input logic [3:0] bb, input bit clr);
        @(negedge clock);
        #1;
        reset = 1'b0; r = rr; g = gg; b = bb; cnt_clear = clr;
        model_step(mdecode(rr, gg, bb), clr);
        @(posedge clock);
        #2;
    endtask

    task automatic col(input int ci, input bit clr = 1'b0);
        logic [11:0] p;
        p = pat[ci];
        step(p[11:8], p[7:4], p[3:0], clr);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #1;
        reset = 1'b1; cnt_clear = 1'b0;
        model_reset();
        @(posedge clock);
        #2;
    endtask

    int exp_err1[5] = '{1, 2, 3, 3, 3};

    initial begin
        model_reset();
        do_reset();
        chk_en = 1'b1;
        do_reset();
        check("reset color_idx", ci0, 7);
        check("reset locked", lk0, 0);
        check("reset lap", lap0, 0);

        // Full lap red..magenta, red.
        col(RED);
        check("locked after first red", lk0, 1);
        for (int i = YEL; i <= MAG; i++) col(i);
        col(RED);
        check("u0 lap after lap", lap0, 1);
        check("u1 lap after lap", lap1, 1);

        // Lock at green, stop for 3 cycles, restart at red.
        col(YEL); col(GRN);
        for (int i = 0; i < 3; i++) col(OFF);
        check("halted while off", hl0, 1);
        col(RED);
        check("locked after restart", lk0, 1);
        check("lap unchanged by restart", lap0, 1);
        check("no errors yet", err0, 0);

        // Skip yellow: red -> green.
        col(GRN);
        check("skip seq_error", se0, 1);
        check("skip err_count", err0, 1);
        check("skip leaves lock", lk0, 0);
        col(CYN);
        check("seq_error one cycle", se0, 0);
        check("relock at cyan", lk0, 1);
        col(BLU);
        check("blue follows cyan", se0, 0);

        // Partial nibble while tracking, then held while acquiring.
        step(4'b0111, 4'h0, 4'h0, 1'b0);
        check("partial color_idx", ci0, 7);
        check("partial seq_error", se0, 1);
        check("partial err_count", err0, 2);
        for (int i = 0; i < 3; i++) step(4'b0111, 4'h0, 4'h0, 1'b0);
        check("partial held err_count", err0, 2);

        // Hold behaviour: red, red, yellow (counters cleared on first red).
        col(RED, 1'b1);
        col(RED);
        check("hold0 error on repeat", se0, 1);
        check("hold0 err_count", err0, 1);
        check("hold1 no error", se1, 0);
        col(YEL);
        check("hold1 locked", lk1, 1);
        col(GRN);
        check("hold1 prev was yellow", se1, 0);

        // Error saturation on ERR_W=2, then clear against a 6th error.
        col(OFF, 1'b1);
        for (int i = 0; i < 5; i++) begin
            col(RED);
            col(GRN);
            check("sat seq_error", se1, 1);
            check("sat err_count", err1, exp_err1[i]);
        end
        check("u0 five errors", err0, 5);
        col(RED);
        col(GRN, 1'b1);
        check("clear beats error u1", err1, 0);
        check("clear beats error u0", err0, 0);
        check("error pulses under clear", se1, 1);

        // Eight laps: LAP_W=3 wraps to 0.
        col(RED);
        for (int l = 0; l < 8; l++)
            for (int i = YEL; i <= RED + 6; i++) col(i % 6);
        check("u0 eight laps", lap0, 8);
        check("u1 lap wraps", lap1, 0);
        for (int i = YEL; i <= MAG; i++) col(i);
        col(RED, 1'b1);
        check("clear beats lap", lap0, 0);

        // Invalid colour in HALTED; off while acquiring halts without error.
        col(OFF);
        col(BLU);
        check("halted bad restart", se0, 1);
        col(OFF);
        check("acquire to halted", hl0, 1);
        check("acquire off no error", se0, 0);

        // Reset mid-sequence abandons the lap.
        col(RED); col(YEL); col(GRN);
        do_reset();
        check("mid reset err", err0, 0);
        col(CYN);
        check("reacquire at cyan", lk0, 1);
        col(BLU); col(MAG); col(RED);
        check("partial lap after reset", lap0, 1);
        col(YEL);

        @(negedge clock);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/crazy_light_monitor.md
Name: crazy_light_monitor

Overview:
- Receive-side checker for the RGB colour sequencer's r/g/b outputs, sampled in the same clock domain.
- Decodes each sample to a colour index and checks that the sequence is legal: red, yellow, green, cyan, blue, magenta, then wrap to red; all-off while stopped.
- Reports lock/halt status, sequence-error pulses, completed laps and an error count to the board status logic and the testbench scoreboard.

Parameters:
- LAP_W, 8, width of lap counter; wraps modulo 2^LAP_W.
- ERR_W, 8, width of error counter; saturates at 2^ERR_W-1.
- ALLOW_HOLD, 0, 1 = a colour repeated on consecutive cycles is legal; 0 = a repeat is an error.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- r  in  4  red channel from sequencer.
- g  in  4  green channel from sequencer.
- b  in  4  blue channel from sequencer.
- cnt_clear  in  1  synchronous clear of lap_count and err_count.
- color_idx  out  3  registered decode of the last sample.
- locked  out  1  high while FSM in TRACK.
- halted  out  1  high while FSM in HALTED.
- seq_error  out  1  one-cycle pulse on an illegal transition.
- lap_count  out  LAP_W  completed 5-to-0 wraps.
- err_count  out  ERR_W  number of seq_error pulses.

Behaviour:
- Interface: one clock, `clock`. Reset `reset` is synchronous, active-high, sampled on the rising edge of `clock`.
- Decode (combinational on the inputs; channel "on" = 4'b1111, "off" = 4'b0000):
  - 0 red = (on, off, off); 1 yellow = (on, on, off); 2 green = (off, on, off).
  - 3 cyan = (off, on, on); 4 blue = (off, off, on); 5 magenta = (on, off, on).
  - 6 off = all off; 7 invalid = any other pattern, including partial nibbles.
- Latency:
  - color_idx, the FSM state and all status outputs update on the edge that samples r/g/b.
  - seq_error is high for exactly the cycle after the offending sample.
- Reset values: state ACQUIRE, color_idx=7, locked=0, halted=0, seq_error=0, lap_count=0, err_count=0, prev=0.
- Internal prev (3 bits) holds the last accepted colour index.
- FSM, with c = decoded sample each cycle:
  - ACQUIRE:
    - c in 0..5: go to TRACK, prev=c.
    - c=6: go to HALTED.
    - c=7: stay. No error is ever flagged in ACQUIRE.
  - TRACK:
    - c=(prev+1) mod 6: stay, prev=c. If prev=5 and c=0, lap_count += 1.
    - c=6: go to HALTED. Stop is legal from any colour.
    - c=prev with ALLOW_HOLD=1: stay, no change.
    - Anything else (skip, backward step, repeat with ALLOW_HOLD=0, invalid): pulse seq_error, err_count += 1, go to ACQUIRE.
  - HALTED:
    - c=6: stay.
    - c=0: go to TRACK, prev=0. Restart is not a lap.
    - Any other c, including 7: pulse seq_error, err_count += 1, go to ACQUIRE.
  - The re-lock after an error happens on the next sample, not on the offending one.
- Status outputs: locked = (state==TRACK); halted = (state==HALTED). Both are registered with the state.
- Counters:
  - lap_count wraps from 2^LAP_W-1 to 0.
  - err_count holds at 2^ERR_W-1; seq_error still pulses while saturated.
  - cnt_clear has priority over a same-cycle increment: the result is 0 and the increment is lost.
  - cnt_clear does not affect the FSM, prev or color_idx.
- Priority: reset over everything. A reset mid-sequence abandons the lap in progress, and the next sample re-acquires.
- No gated clocks, no latches. All outputs are driven from flops.

Test Plan:
- Reset, then drive red..magenta, red on consecutive cycles:
  - locked=1 from the cycle after the first red.
  - lap_count=1 after the second red.
  - seq_error never asserted.
- Lock at green, then drive all-off for 3 cycles, then red:
  - halted=1 while off.
  - locked=1 after red.
  - lap_count unchanged; err_count=0.
- Lock at red, then drive green (skip yellow):
  - seq_error pulses for 1 cycle; err_count=1; FSM goes to ACQUIRE.
  - A following cyan re-locks with prev=3.
- Drive r=4'b0111, g=0, b=0 while tracking:
  - color_idx=7, seq_error=1, err_count increments.
  - The same pattern held in ACQUIRE produces no further errors.
- ALLOW_HOLD=0 vs 1, sequence red, red, yellow:
  - Hold=0: error on the second red, err_count=1.
  - Hold=1: no error, ends locked with prev=1.
- ERR_W=2, inject 5 errors: err_count goes 1, 2, 3, 3, 3.
  - Assert cnt_clear together with a 6th error: err_count=0.
